bus_dma: RTL and testbench
==========================

BUS_DMA -- requirements
Module: bus_dma

Interface
REQ-001 The module SHALL use one clock and one reset: reset is asynchronous and active-high.
REQ-002 CLK_I  input  1  system clock; all state changes on its rising edge.
REQ-003 RST_I  input  1  asynchronous active-high reset.
REQ-004 ADD_I  input  2  slave register select: 0 SRC, 1 DST, 2 LEN, 3 CTRL.
REQ-005 WE_I  input  1  slave register write enable, sampled at the rising edge.
REQ-006 DAT_I  input  32  slave write data.
REQ-007 DAT_O  output  32  slave read data, combinational on ADD_I.
REQ-008 IRQ  output  1  interrupt, high while DONE=1 and IE=1.
REQ-009 M_REQ  output  1  master access request.
REQ-010 M_GNT  input  1  access granted this cycle; the access completes at the next rising edge.
REQ-011 M_ADDR  output  30  master word address [31:2].
REQ-012 M_WE  output  1  master write strobe, valid only with M_REQ.
REQ-013 M_BE  output  4  byte enables; always 4'b1111 while M_REQ=1, else 0.
REQ-014 M_WD  output  32  master write data.
REQ-015 M_RD  input  32  master read data, valid in the granted read cycle.

Function
REQ-016 Registers: SRC[31:2], DST[31:2] word pointers (bits 1:0 read 0); LEN[15:0] word count, upper bits read 0; CTRL write bit0 GO, bit1 IE, bit2 DCLR.
REQ-017 CTRL read SHALL return {29'b0, BUSY, DONE, IE}.
REQ-018 Writes to SRC, DST and LEN while BUSY=1 SHALL be ignored; IE and DCLR writes SHALL be accepted at any time.
REQ-019 FSM states IDLE, RD, WR, FIN.
- IDLE: a CTRL write with GO=1 moves to RD if LEN!=0, else to FIN; DONE cleared.
- GO while BUSY is ignored.
REQ-020 RD: M_REQ=1, M_WE=0, M_ADDR=SRC. On an edge with M_GNT=1, M_RD is latched into a 32-bit buffer, SRC increments by 1 and the FSM moves to WR.
REQ-021 WR: M_REQ=1, M_WE=1, M_ADDR=DST, M_WD=buffer. On an edge with M_GNT=1, DST increments and LEN decrements. The FSM moves to RD if the new LEN!=0, else to FIN.
REQ-022 While M_GNT=0 in RD/WR, every master output and every register SHALL hold unchanged.
REQ-023 FIN: sets DONE=1 for one cycle, then returns to IDLE; M_REQ=0.
REQ-024 BUSY=1 in RD, WR and FIN.
REQ-025 Pointer increments SHALL wrap modulo 2^30.
REQ-026 The slave reads SRC, DST and LEN SHALL return live (progressing) values.
REQ-027 A DCLR write SHALL clear DONE. If the DCLR write coincides with FIN setting DONE, the set wins.
REQ-028 Minimum transfer time SHALL be 2*LEN+1 cycles from the GO edge to DONE=1, with M_GNT held at 1.
REQ-029 M_REQ, M_WE and M_BE SHALL be 0 in IDLE and FIN. M_ADDR and M_WD are don't-care there and driven 0.

Reset
REQ-030 RST_I=1 SHALL immediately force the following regardless of clock:
- FSM to IDLE
- SRC, DST, LEN, buffer, IE and DONE to 0
- M_REQ, M_WE and IRQ to 0, M_BE to 0, DAT_O to 0 for all ADD_I
REQ-031 A reset during RD or WR SHALL abort the transfer with no further master access after release; an access in flight is not completed.

Verification
REQ-032 Program SRC=0x100, DST=0x200 (byte addresses), LEN=3, CTRL=0x3 with M_GNT=1 -> the master performs reads at word 0x40, 0x41, 0x42 interleaved with writes at 0x80, 0x81, 0x82. The write data equals the read data. DONE=1 and IRQ=1 at cycle 7 after GO.
REQ-033 LEN=0, CTRL=0x1 -> M_REQ stays 0; CTRL read returns 0x2 one cycle later; IRQ stays 0.
REQ-034 M_GNT=0 for 5 cycles during the first WR -> M_ADDR, M_WD and M_WE stable for those 5 cycles; the transfer completes correctly after the grant returns.
REQ-035 SRC=0xFFFFFFFC, LEN=2 -> the second read address is word 0x00000000.
REQ-036 Assert RST_I mid-transfer (LEN=4, after 2 writes) -> all outputs 0 asynchronously. The CTRL read is 0 after release, and there is no M_REQ until a new GO.
REQ-037 While BUSY, write LEN=9 and GO -> both ignored; the original count completes. Then write CTRL=0x4 -> DONE=0 and IRQ=0.

Source files
------------

// File: rtl/bus_dma_if.sv
// bus_dma_if: register slave port and memory master port of the word-copy DMA
interface bus_dma_if;
  logic [1:0] ADD_I;
  logic WE_I;
  logic [31:0] DAT_I;
  logic [31:0] DAT_O;
  logic IRQ;
  logic M_REQ;
  logic M_GNT;
  logic [29:0] M_ADDR;
  logic M_WE;
  logic [3:0] M_BE;
  logic [31:0] M_WD;
  logic [31:0] M_RD;
  modport master (input ADD_I, WE_I, DAT_I, M_GNT, M_RD, output DAT_O, IRQ, M_REQ, M_ADDR, M_WE, M_BE, M_WD);
  modport slave (output ADD_I, WE_I, DAT_I, M_GNT, M_RD, input DAT_O, IRQ, M_REQ, M_ADDR, M_WE, M_BE, M_WD);
endinterface

// File: rtl/bus_dma.sv
// bus_dma: single-channel DMA copying LEN words from SRC to DST, one read then one write per word
module bus_dma (
  input logic CLK_I,
  input logic RST_I,
  bus_dma_if.master bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;
  state_t state, stateNext;
  logic [29:0] src, dst;
  logic [15:0] len;
  logic [31:0] buffer;
  logic ie, done, busy, ctrlWr, regWr, req;
  assign busy = state != IDLE;
  assign ctrlWr = bus.WE_I && bus.ADD_I == 2'd3;
  assign regWr = bus.WE_I && !busy;
  assign req = state == RD || state == WR;
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) state <= IDLE;
    else state <= stateNext;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: stateNext = ctrlWr && bus.DAT_I[0] ? (len != 16'd0 ? RD : FIN) : IDLE;
      RD: stateNext = bus.M_GNT ? WR : RD;
      WR: stateNext = !bus.M_GNT ? WR : len != 16'd1 ? RD : FIN;
      default: stateNext = IDLE;
    endcase
    bus.M_REQ = req;
    bus.M_WE = state == WR;
    bus.M_BE = {4{req}};
    bus.M_ADDR = state == RD ? src : state == WR ? dst : 30'd0;
    bus.M_WD = state == WR ? buffer : 32'd0;
    bus.IRQ = done && ie;
    bus.DAT_O = bus.ADD_I == 2'd0 ? {src, 2'b00} :
                bus.ADD_I == 2'd1 ? {dst, 2'b00} :
                bus.ADD_I == 2'd2 ? {16'd0, len} : {29'd0, busy, done, ie};
  end
  always_ff @(posedge CLK_I or posedge RST_I)
    if (RST_I) begin
      src <= '0;
      dst <= '0;
      len <= '0;
      buffer <= '0;
      ie <= 1'b0;
      done <= 1'b0;
    end else begin
      if (regWr && bus.ADD_I == 2'd0) src <= bus.DAT_I[31:2];
      else if (state == RD && bus.M_GNT) src <= src + 30'd1;
      if (regWr && bus.ADD_I == 2'd1) dst <= bus.DAT_I[31:2];
      else if (state == WR && bus.M_GNT) dst <= dst + 30'd1;
      if (regWr && bus.ADD_I == 2'd2) len <= bus.DAT_I[15:0];
      else if (state == WR && bus.M_GNT) len <= len - 16'd1;
      if (state == RD && bus.M_GNT) buffer <= bus.M_RD;
      if (ctrlWr) ie <= bus.DAT_I[1];
      // a DONE set from FIN outranks a coincident DCLR
      if (state == FIN) done <= 1'b1;
      else if (ctrlWr && (bus.DAT_I[2] || (bus.DAT_I[0] && !busy))) done <= 1'b0;
    end
endmodule

// File: tb/tb_bus_dma.sv
// tb_bus_dma: random and directed stimulus checked against a transaction-level copy model
module tb_bus_dma;
  logic CLK_I, RST_I;
  bus_dma_if bif ();
  bus_dma dut (.CLK_I(CLK_I), .RST_I(RST_I), .bus(bif.master));
  typedef struct packed {logic we; logic [29:0] addr;} acc_t;
  acc_t q[$];
  logic [29:0] mSrc, mDst;
  logic [15:0] mLen;
  logic [31:0] lastRd;
  logic mIe, mDone;
  bit finPend, randGnt;
  int checks = 0, errors = 0;
  initial CLK_I = 1'b0;
  always #10 CLK_I = ~CLK_I;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask
  // model: a GO expands into the full list of expected accesses; grants consume it
  always @(posedge CLK_I or posedge RST_I) begin
    acc_t h;
    bit finNow, busyNow;
    if (RST_I) begin
      mSrc = '0; mDst = '0; mLen = '0; mIe = 0; mDone = 0; finPend = 0; lastRd = '0;
      q.delete();
    end else begin
      finNow = finPend;
      busyNow = q.size() != 0 || finPend;
      if (finNow) begin mDone = 1; finPend = 0; end
      if (q.size() != 0 && bif.M_GNT) begin
        h = q.pop_front();
        if (!h.we) begin lastRd = bif.M_RD; mSrc = mSrc + 30'd1; end
        else begin
          mDst = mDst + 30'd1; mLen = mLen - 16'd1;
          if (q.size() == 0) finPend = 1;
        end
      end
      if (bif.WE_I) begin
        if (bif.ADD_I == 2'd0 && !busyNow) mSrc = bif.DAT_I[31:2];
        if (bif.ADD_I == 2'd1 && !busyNow) mDst = bif.DAT_I[31:2];
        if (bif.ADD_I == 2'd2 && !busyNow) mLen = bif.DAT_I[15:0];
        if (bif.ADD_I == 2'd3) begin
          mIe = bif.DAT_I[1];
          if (bif.DAT_I[2] && !finNow) mDone = 0;
          if (bif.DAT_I[0] && !busyNow) begin
            mDone = 0;
            for (int i = 0; i < int'(mLen); i++) begin
              q.push_back('{1'b0, 30'(mSrc + 30'(i))});
              q.push_back('{1'b1, 30'(mDst + 30'(i))});
            end
            if (mLen == 0) finPend = 1;
          end
        end
      end
    end
  end
  always @(negedge CLK_I) begin
    acc_t h;
    bit act, busyM;
    logic [31:0] expDat;
    act = q.size() != 0;
    h = act ? q[0] : '0;
    busyM = act || finPend;
    expDat = bif.ADD_I == 2'd0 ? {mSrc, 2'b00} : bif.ADD_I == 2'd1 ? {mDst, 2'b00} :
             bif.ADD_I == 2'd2 ? {16'd0, mLen} : {29'd0, busyM, mDone, mIe};
    check("M_REQ", 32'(bif.M_REQ), 32'(act));
    check("M_WE", 32'(bif.M_WE), 32'(act && h.we));
    check("M_BE", 32'(bif.M_BE), act ? 32'hF : 32'h0);
    check("M_ADDR", 32'(bif.M_ADDR), 32'(h.addr));
    check("M_WD", bif.M_WD, act && h.we ? lastRd : 32'h0);
    check("IRQ", 32'(bif.IRQ), 32'(mDone && mIe));
    check("DAT_O", bif.DAT_O, expDat);
  end
  task automatic tick();
    @(posedge CLK_I);
    #1;
    bif.M_RD = $urandom;
    if (randGnt) bif.M_GNT = $urandom_range(0, 3) != 0;
  endtask
  task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
    bif.ADD_I = a; bif.DAT_I = d; bif.WE_I = 1;
    tick();
    bif.WE_I = 0;
  endtask
  task automatic waitIdle(input bit rw);
    int n = 0;
    while ((q.size() != 0 || finPend) && n < 400) begin
      if (rw && $urandom_range(0, 3) == 0) begin
        bif.ADD_I = 2'($urandom); bif.DAT_I = $urandom; bif.WE_I = 1;
      end else bif.WE_I = 0;
      tick();
      n++;
    end
    bif.WE_I = 0;
    if (n >= 400) begin
      checks++; errors++;
      $display("FAIL idle_timeout: still busy after %0d cycles, limit 400", n);
    end
  endtask
  task automatic readReg(input string nm, input logic [1:0] a, input logic [31:0] exp);
    bif.ADD_I = a;
    #1;
    check(nm, bif.DAT_O, exp);
  endtask
  initial begin
    logic [29:0] hAddr;
    logic [31:0] hWd;
    logic hWe;
    logic [29:0] expA [6];
    expA = '{30'h40, 30'h80, 30'h41, 30'h81, 30'h42, 30'h82};
    RST_I = 1; randGnt = 0;
    bif.ADD_I = 0; bif.WE_I = 0; bif.DAT_I = 0; bif.M_GNT = 0; bif.M_RD = 0;
    tick(); tick();
    readReg("reset_ctrl", 2'd3, 32'h0);
    RST_I = 0;
    tick();
    // basic three-word copy with grant always present
    bif.M_GNT = 1;
    regWrite(2'd0, 32'h100); regWrite(2'd1, 32'h200); regWrite(2'd2, 32'd3); regWrite(2'd3, 32'h3);
    for (int k = 0; k < 6; k++) begin
      check("seq_addr", 32'(bif.M_ADDR), 32'(expA[k]));
      check("seq_we", 32'(bif.M_WE), 32'(k % 2));
      tick();
    end
    readReg("fin_ctrl", 2'd3, 32'h5);
    tick();
    readReg("done_ctrl", 2'd3, 32'h3);
    check("done_irq", 32'(bif.IRQ), 32'h1);
    // zero-length GO goes straight through FIN
    regWrite(2'd2, 32'd0); regWrite(2'd3, 32'h1);
    readReg("len0_busy", 2'd3, 32'h4);
    check("len0_req", 32'(bif.M_REQ), 32'h0);
    tick();
    readReg("len0_done", 2'd3, 32'h2);
    check("len0_irq", 32'(bif.IRQ), 32'h0);
    // grant withheld during the first write
    regWrite(2'd0, 32'h1000); regWrite(2'd1, 32'h2000); regWrite(2'd2, 32'd2); regWrite(2'd3, 32'h3);
    tick();
    bif.M_GNT = 0;
    hAddr = bif.M_ADDR; hWd = bif.M_WD; hWe = bif.M_WE;
    check("stall_addr0", 32'(hAddr), 32'h800);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_addr", 32'(bif.M_ADDR), 32'(hAddr));
      check("stall_wd", bif.M_WD, hWd);
      check("stall_we", 32'(bif.M_WE), 32'(hWe));
    end
    bif.M_GNT = 1;
    waitIdle(0);
    readReg("stall_src", 2'd0, 32'h1008);
    readReg("stall_dst", 2'd1, 32'h2008);
    readReg("stall_len", 2'd2, 32'h0);
    // source pointer wraps modulo 2^30
    regWrite(2'd0, 32'hFFFFFFFC); regWrite(2'd1, 32'h10); regWrite(2'd2, 32'd2); regWrite(2'd3, 32'h3);
    check("wrap_rd0", 32'(bif.M_ADDR), 32'h3FFFFFFF);
    tick(); tick();
    check("wrap_rd1", 32'(bif.M_ADDR), 32'h0);
    check("wrap_we1", 32'(bif.M_WE), 32'h0);
    waitIdle(0);
    // asynchronous reset in the middle of a transfer
    regWrite(2'd0, 32'h400); regWrite(2'd1, 32'h800); regWrite(2'd2, 32'd4); regWrite(2'd3, 32'h3);
    tick(); tick(); tick(); tick();
    #2 RST_I = 1;
    #1;
    check("rst_req", 32'(bif.M_REQ), 32'h0);
    check("rst_we", 32'(bif.M_WE), 32'h0);
    check("rst_be", 32'(bif.M_BE), 32'h0);
    check("rst_addr", 32'(bif.M_ADDR), 32'h0);
    check("rst_irq", 32'(bif.IRQ), 32'h0);
    tick();
    for (int a = 0; a < 4; a++) readReg("rst_dat", 2'(a), 32'h0);
    RST_I = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_rst_req", 32'(bif.M_REQ), 32'h0);
      readReg("post_rst_ctrl", 2'd3, 32'h0);
    end
    // LEN and GO writes while busy are dropped
    regWrite(2'd0, 32'h0); regWrite(2'd1, 32'h100); regWrite(2'd2, 32'd3); regWrite(2'd3, 32'h3);
    tick();
    regWrite(2'd2, 32'd9); regWrite(2'd3, 32'h3);
    waitIdle(0);
    readReg("busy_len", 2'd2, 32'h0);
    readReg("busy_dst", 2'd1, 32'h10C);
    readReg("busy_done", 2'd3, 32'h3);
    regWrite(2'd3, 32'h4);
    readReg("dclr_ctrl", 2'd3, 32'h0);
    check("dclr_irq", 32'(bif.IRQ), 32'h0);
    // randomized transfers with random grants and stray register writes
    randGnt = 1;
    for (int t = 0; t < 30; t++) begin
      regWrite(2'd0, $urandom); regWrite(2'd1, $urandom);
      regWrite(2'd2, 32'($urandom_range(0, 6)));
      regWrite(2'd3, {29'd0, 1'($urandom), 1'($urandom), 1'b1});
      waitIdle(1);
    end
    randGnt = 0;
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
